spi_master_t: RTL and testbench

Byte-wide SPI master (mode 0, MSB first) that sits directly downstream of soc_t's peripheral bus and drives the ULX3S SD-card pins (sd_clk, sd_cmd, sd_d3, sd_d0).
- The CPU-side register logic hands it one byte per transfer over a valid/ready handshake.
- It receives the simultaneously shifted-in byte as a one-cycle pulse.
- Chip select and SCK rate are software-controlled, so the same block serves slow SD init (<400 kHz) and fast data phases.

---
 rtl/spi_master_t.sv | 151 +++++++++++++++
 tb/tb_spi_master_t.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_t.sv
// rtl/spi_master_t.sv - byte-wide SPI master, mode 0, MSB first
//
// Purpose: shifts one byte out on spi_mosi while shifting one byte in from
// spi_miso, with a per-transfer SCK rate and a software-driven chip select.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   tx_valid/tx_ready     byte handshake; accepted when both are high on a clk edge
//   tx_data, half_period  byte to send and SCK half-period minus one (sampled at accept)
//   rx_valid, rx_data     one-cycle pulse with the received byte; rx_data holds
//   cs_wr, cs_level       chip-select write strobe and level
//   spi_clk, spi_mosi     SCK and MOSI
//   spi_miso              MISO
//   spi_cs                chip select, active low
module spi_master_t #(
  parameter int   DIV_WIDTH = 8,
  parameter logic CS_IDLE   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [7:0]           tx_data,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  input  logic                 cs_wr,
  input  logic                 cs_level,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 spi_cs
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] hp, hp_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [7:0]           tx_shift, tx_shift_n;
  logic [7:0]           rx_shift, rx_shift_n;
  logic [7:0]           rx_data_n;
  logic                 tx_ready_n, rx_valid_n, sclk_n, mosi_n, cs_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hp       <= '0;
      cnt      <= '0;
      bit_cnt  <= 3'd0;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b1;
      spi_cs   <= CS_IDLE;
    end else begin
      state    <= state_n;
      hp       <= hp_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      tx_shift <= tx_shift_n;
      rx_shift <= rx_shift_n;
      rx_data  <= rx_data_n;
      tx_ready <= tx_ready_n;
      rx_valid <= rx_valid_n;
      spi_clk  <= sclk_n;
      spi_mosi <= mosi_n;
      spi_cs   <= cs_n;
    end
  end

  always_comb begin
    state_n    = state;
    hp_n       = hp;
    cnt_n      = cnt;
    bit_n      = bit_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data;
    tx_ready_n = tx_ready;
    rx_valid_n = 1'b0;
    sclk_n     = spi_clk;
    mosi_n     = spi_mosi;
    // Chip select is independent of the shifter so it can move in any state.
    cs_n       = cs_wr ? cs_level : spi_cs;

    case (state)
      IDLE: begin
        sclk_n     = 1'b0;
        mosi_n     = 1'b1;
        tx_ready_n = 1'b1;
        if (tx_valid && tx_ready) begin
          tx_shift_n = tx_data;
          hp_n       = half_period;
          cnt_n      = half_period;
          bit_n      = 3'd0;
          mosi_n     = tx_data[7];
          tx_ready_n = 1'b0;
          state_n    = LOW;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          // Rising SCK edge: MISO has been stable since the previous fall.
          sclk_n     = 1'b1;
          rx_shift_n = {rx_shift[6:0], spi_miso};
          cnt_n      = hp;
          state_n    = HIGH;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          sclk_n = 1'b0;
          if (bit_cnt == 3'd7) begin
            state_n = DONE;
          end else begin
            bit_n      = bit_cnt + 3'd1;
            tx_shift_n = {tx_shift[6:0], 1'b0};
            mosi_n     = tx_shift[6];
            cnt_n      = hp;
            state_n    = LOW;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      DONE: begin
        rx_data_n  = rx_shift;
        rx_valid_n = 1'b1;
        mosi_n     = 1'b1;
        tx_ready_n = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_t.sv
// tb/tb_spi_master_t.sv - self-checking bench for spi_master_t
module tb_spi_master_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] half_period = 8'h00;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cs_wr = 1'b0;
  logic       cs_level = 1'b1;
  logic       spi_clk, spi_mosi, spi_miso, spi_cs;

  logic       loop_mode = 1'b0;
  logic       miso_bit = 1'b0;
  assign spi_miso = loop_mode ? spi_mosi : miso_bit;

  int         vectors = 0;
  int         miscompares = 0;
  logic       exp_cs = 1'b1;
  logic [7:0] prev_rx = 8'h00;

  spi_master_t #(.DIV_WIDTH(8), .CS_IDLE(1'b1)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .half_period(half_period), .rx_valid(rx_valid),
    .rx_data(rx_data), .cs_wr(cs_wr), .cs_level(cs_level), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},       spi_cs,   1'b1);
    check({tag, "_mosi"},     spi_mosi, 1'b1);
    check({tag, "_clk"},      spi_clk,  1'b0);
    check({tag, "_ready"},    tx_ready, 1'b1);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_rx_data"},  rx_data,  8'h00);
  endtask

  task automatic present(input logic [7:0] d, input logic [7:0] hp);
    tx_valid    = 1'b1;
    tx_data     = d;
    half_period = hp;
    cs_wr       = 1'b0;
  endtask

  task automatic cs_write(input logic lvl);
    @(negedge clk);
    cs_wr = 1'b1;
    cs_level = lvl;
    @(negedge clk);
    cs_wr = 1'b0;
    check("cs_write", spi_cs, lvl);
    exp_cs = lvl;
  endtask

  // Called just after a negedge where the byte has been presented and the DUT
  // is idle. mode 0: inputs disturbed but tx_valid low; 1: random tx_valid,
  // data, rate and chip-select writes; 2: tx_valid held high with the next
  // byte waiting. Returns at the rx_valid sample (chain) or one sample later.
  task automatic run_xfer(input logic [7:0] d, input logic [7:0] hp, input bit lb,
                          input logic [7:0] mb, input int mode, input int cs_at,
                          input logic cs_lvl, input bit chain,
                          input logic [7:0] nd, input logic [7:0] nhp);
    int P, E, L, lat, rises, sclk_err, mosi_err, stat_err;
    logic [7:0] exp_rx, mb_sh, rx_obs;
    logic prev_sclk, cs_pv, cs_pl, es, em;
    P = int'(hp) + 1;
    E = 16 * P;
    L = E + 1;
    lat = -1;
    rises = 0; sclk_err = 0; mosi_err = 0; stat_err = 0;
    exp_rx = lb ? d : mb;
    rx_obs = 8'h00;
    prev_sclk = 1'b0;
    cs_pv = 1'b0;
    cs_pl = 1'b0;
    @(posedge clk);
    loop_mode = lb;
    mb_sh = mb;
    miso_bit = mb[7];
    for (int k = 0; k <= L + 8; k++) begin
      @(negedge clk);
      if (cs_pv) begin
        exp_cs = cs_pl;
        cs_pv = 1'b0;
      end
      if (spi_cs !== exp_cs) stat_err++;
      if (k <= L) begin
        if (k < E) begin
          es = ((k / P) % 2) != 0;
          em = d[7 - k / (2 * P)];
        end else begin
          es = 1'b0;
          em = (k == E) ? d[0] : 1'b1;
        end
        if (spi_clk !== es) sclk_err++;
        if (spi_mosi !== em) mosi_err++;
        if (tx_ready !== (k >= L)) stat_err++;
        if (k < L && rx_data !== prev_rx) stat_err++;
        if (spi_clk === 1'b1 && prev_sclk === 1'b0) rises++;
      end
      if (prev_sclk === 1'b1 && spi_clk === 1'b0) begin
        mb_sh = {mb_sh[6:0], 1'b0};
        miso_bit = mb_sh[7];
      end
      prev_sclk = spi_clk;
      if (rx_valid === 1'b1) begin
        lat = k;
        rx_obs = rx_data;
        cs_wr = 1'b0;
        if (chain) present(nd, nhp);
        else tx_valid = 1'b0;
        break;
      end
      case (mode)
        1: begin
          tx_valid = (k < E) ? 1'($urandom % 2) : 1'b0;
          tx_data = 8'($urandom);
          half_period = 8'($urandom);
          cs_wr = ($urandom % 6) == 0;
          cs_level = 1'($urandom % 2);
        end
        2: begin
          tx_valid = 1'b1;
          tx_data = nd;
          half_period = nhp;
          cs_wr = (k == cs_at);
          cs_level = cs_lvl;
        end
        default: begin
          tx_valid = 1'b0;
          tx_data = ~d;
          half_period = 8'h00;
          cs_wr = (k == cs_at);
          cs_level = cs_lvl;
        end
      endcase
      if (cs_wr) begin
        cs_pv = 1'b1;
        cs_pl = cs_level;
      end
    end
    if (lat < 0) begin
      tx_valid = 1'b0;
      cs_wr = 1'b0;
      rx_obs = rx_data;
    end
    check("latency",   lat,      L);
    check("rx_data",   rx_obs,   exp_rx);
    check("sck_rises", rises,    8);
    check("sck_shape", sclk_err, 0);
    check("mosi_seq",  mosi_err, 0);
    check("status",    stat_err, 0);
    prev_rx = exp_rx;
    if (!chain) begin
      @(negedge clk);
      check("rx_valid_pulse", rx_valid, 1'b0);
      check("idle_lines", {tx_ready, spi_clk, spi_mosi}, 3'b101);
    end
  endtask

  initial begin
    logic [7:0] cur_d, cur_hp, nd, nhp, mb;
    bit lb, chain;
    int rx_seen;

    // Reset values while reset is held from time zero.
    #12;
    check_reset_outputs("rst_initial");
    @(negedge clk);
    reset = 1'b0;

    // Chip select low, then loopback A5 at the fastest rate.
    cs_write(1'b0);
    present(8'hA5, 8'd0);
    run_xfer(8'hA5, 8'd0, 1'b1, 8'h00, 0, -1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Asynchronous reset in the middle of a clock cycle.
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    reset = 1'b0;
    exp_cs = 1'b1;
    prev_rx = 8'h00;

    // Slow rate with MISO held high; rate input changes mid-transfer.
    @(negedge clk);
    present(8'h3C, 8'd3);
    run_xfer(8'h3C, 8'd3, 1'b0, 8'hFF, 0, -1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Chip select, then a zero transfer with a mid-transfer deassert.
    cs_write(1'b0);
    present(8'h00, 8'd1);
    run_xfer(8'h00, 8'd1, 1'b0, 8'h00, 0, 10, 1'b1, 1'b0, 8'h00, 8'h00);

    // Busy handling: second byte waits until the rx_valid cycle.
    @(negedge clk);
    present(8'h11, 8'd1);
    run_xfer(8'h11, 8'd1, 1'b1, 8'h00, 2, -1, 1'b0, 1'b1, 8'h22, 8'd1);
    run_xfer(8'h22, 8'd1, 1'b1, 8'h00, 0, -1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset after three bits of a transfer.
    cs_write(1'b0);
    @(negedge clk);
    present(8'h96, 8'd2);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_mid_xfer");
    @(negedge clk);
    reset = 1'b0;
    exp_cs = 1'b1;
    prev_rx = 8'h00;
    rx_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0 || tx_ready !== 1'b1) rx_seen++;
    end
    check("quiet_after_reset", rx_seen, 0);
    present(8'h5A, 8'd2);
    run_xfer(8'h5A, 8'd2, 1'b1, 8'h00, 0, -1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Randomized transfers, some back-to-back, with random bus noise.
    cur_d = 8'($urandom);
    cur_hp = 8'($urandom % 5);
    @(negedge clk);
    present(cur_d, cur_hp);
    for (int i = 0; i < 20; i++) begin
      nd = 8'($urandom);
      nhp = 8'($urandom % 5);
      mb = 8'($urandom);
      lb = 1'($urandom % 2);
      chain = (i < 19) ? 1'($urandom % 2) : 1'b0;
      run_xfer(cur_d, cur_hp, lb, mb, 1, -1, 1'b0, chain, nd, nhp);
      if (!chain && i < 19) begin
        repeat ($urandom % 3) @(negedge clk);
        present(nd, nhp);
      end
      cur_d = nd;
      cur_hp = nhp;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
